// File: rtl/lut_fn_pkg.sv
// Shared types and constants for the programmable LUT function bank.
package lut_fn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int K_MAX = 6;
    localparam int N_MAX = 64;

    // Canonical 4-input truth tables: constant one, 4-way AND, 4-way parity.
    localparam logic [15:0] TT_ONE = 16'hFFFF;
    localparam logic [15:0] TT_AND = 16'h8000;
    localparam logic [15:0] TT_XOR = 16'h6996;

    // The channel counter is at least one bit wide, even for a single channel.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_fn_cell.sv
// One truth-table word with write enable and a K-to-1 combinational read.
// Read latency 0 (registered downstream); a write becomes visible on the next cycle.
module lut_fn_cell
    import lut_fn_pkg::*;
#(
    parameter int K = 4,
    localparam int W = 2 ** K
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we_i,
    input  logic [W-1:0] wdat_i,
    input  logic [K-1:0] sel_i,
    output logic         bit_o
);

    logic [W-1:0] tt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tt_q <= '0;
        end else if (we_i) begin
            tt_q <= wdat_i;
        end
    end

    assign bit_o = tt_q[sel_i];

endmodule

// File: rtl/lut_fn_bank.sv
// Bank of N programmable K-input boolean functions evaluated on one shared vector.
// Evaluation latency 1 cycle, 1 vector/cycle, only while IDLE; inputs are dropped during reload.
module lut_fn_bank
    import lut_fn_pkg::*;
#(
    parameter int K = 4,
    parameter int N = 11,
    localparam int W = 2 ** K
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_start,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_data,
    output logic         cfg_ready,
    output logic         cfg_done,
    output logic         busy,
    input  logic         in_valid,
    input  logic [K-1:0] in_data,
    output logic         out_valid,
    output logic [N-1:0] out_data
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    out_data_q, out_data_d;
    logic [N-1:0]    rd_bits;
    logic            wr_acc;

    assign wr_acc = (state_q == LOAD) && cfg_valid;

    for (genvar j = 0; j < N; j++) begin : g_cell
        lut_fn_cell #(.K(K)) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .we_i   (wr_acc && (cnt_q == CW'(j))),
            .wdat_i (cfg_data),
            .sel_i  (in_data),
            .bit_o  (rd_bits[j])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (cfg_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A vector arriving with cfg_start still sees the old table: state_q is IDLE here.
    always_comb begin
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        if ((state_q == IDLE) && in_valid) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_bits;
        end
    end

    always_comb begin
        cfg_ready = (state_q == LOAD);
        cfg_done  = (state_q == DONE);
        busy      = (state_q == LOAD) || (state_q == DONE);
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_lut_fn_bank.sv
// Directed bench for lut_fn_bank (K=4, N=3) with a queue scoreboard on the evaluation path.
module tb_lut_fn_bank;
    import lut_fn_pkg::*;

    localparam int K = 4;
    localparam int N = 3;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_start, cfg_valid;
    logic [W-1:0] cfg_data;
    logic         cfg_ready, cfg_done, busy;
    logic         in_valid;
    logic [K-1:0] in_data;
    logic         out_valid;
    logic [N-1:0] out_data;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mtab [N];
    logic [N-1:0] exp_q [$];
    logic         pend;
    logic [N-1:0] last_data;

    always #5 clk = ~clk;

    lut_fn_bank #(.K(K), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [K-1:0] d);
        logic [N-1:0] r;
        for (int j = 0; j < N; j++) r[j] = mtab[j][d];
        return r;
    endfunction

    // Drive a vector the bench expects to be evaluated next cycle.
    task automatic eval(input logic [K-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back(model(d));
        pend = 1'b1;
    endtask

    task automatic cyc();
        logic [N-1:0] e;
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, pend});
        if (out_valid === 1'b1) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_data", {29'd0, out_data}, {29'd0, e});
                last_data = e;
            end else begin
                chk("out_valid_unexpected", {31'd0, out_valid}, 32'd0);
            end
        end else begin
            chk("out_data_hold", {29'd0, out_data}, {29'd0, last_data});
        end
        pend = 1'b0;
    endtask

    task automatic chk_cfg(input string tag, input logic rdy, input logic dn, input logic bz);
        chk({tag, "_cfg_ready"}, {31'd0, cfg_ready}, {31'd0, rdy});
        chk({tag, "_cfg_done"},  {31'd0, cfg_done},  {31'd0, dn});
        chk({tag, "_busy"},      {31'd0, busy},      {31'd0, bz});
    endtask

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; pend = 1'b0; last_data = '0;
        for (int j = 0; j < N; j++) mtab[j] = '0;

        // Reset state
        cyc(); cyc();
        chk_cfg("reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        eval(4'hF);
        cyc();
        chk_cfg("post_reset", 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        cyc();

        // Full back-to-back load
        cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
        chk_cfg("load_w0", 1'b1, 1'b0, 1'b1);
        cfg_valid = 1'b1; cfg_data = TT_ONE; cyc();
        chk_cfg("load_w1", 1'b1, 1'b0, 1'b1);
        cfg_data = TT_AND; cyc();
        chk_cfg("load_w2", 1'b1, 1'b0, 1'b1);
        cfg_data = TT_XOR; cyc();
        chk_cfg("load_done", 1'b0, 1'b1, 1'b1);
        cfg_valid = 1'b0;
        mtab[0] = TT_ONE; mtab[1] = TT_AND; mtab[2] = TT_XOR;
        cyc();
        chk_cfg("load_idle", 1'b0, 1'b0, 1'b0);

        // Back-to-back evaluation after load
        chk("model_F", {29'd0, model(4'hF)}, 32'h3);
        chk("model_1", {29'd0, model(4'h1)}, 32'h5);
        eval(4'hF); cyc();
        eval(4'h1); cyc();
        eval(4'h6); cyc();
        eval(4'h0); cyc();
        in_valid = 1'b0;
        cyc();

        // Collision: vector uses old table, LOAD starts the same next cycle
        cfg_start = 1'b1;
        eval(4'hF);
        cyc();
        cfg_start = 1'b0;
        chk_cfg("collision", 1'b1, 1'b0, 1'b1);

        // Gapped load with in_valid held and a stray cfg_start
        in_valid = 1'b1; in_data = 4'h3;
        cfg_valid = 1'b1; cfg_data = 16'h00FF; cyc();
        cfg_valid = 1'b0; cfg_start = 1'b1; in_data = 4'hA; cyc();
        cfg_start = 1'b0;
        chk_cfg("gap_hold", 1'b1, 1'b0, 1'b1);
        cfg_valid = 1'b1; cfg_data = 16'h0F0F; cyc();
        cfg_valid = 1'b0; cfg_data = 16'hFFFF; cyc();
        chk_cfg("gap_hold2", 1'b1, 1'b0, 1'b1);
        cfg_valid = 1'b1; cfg_data = 16'h3C3C; cyc();
        chk_cfg("gap_done", 1'b0, 1'b1, 1'b1);
        cfg_valid = 1'b0;
        mtab[0] = 16'h00FF; mtab[1] = 16'h0F0F; mtab[2] = 16'h3C3C;
        cyc();
        chk_cfg("gap_idle", 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 16; d++) begin
            eval(4'(d));
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        chk_cfg("gap_start_ignored", 1'b0, 1'b0, 1'b0);

        // Reset mid-load clears the whole table
        cfg_start = 1'b1; cyc();
        cfg_start = 1'b0;
        cfg_valid = 1'b1; cfg_data = 16'hAAAA; cyc();
        cfg_data = 16'h5555; cyc();
        chk_cfg("midload", 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0; cfg_valid = 1'b0;
        last_data = '0;
        cyc();
        chk_cfg("midload_reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int j = 0; j < N; j++) mtab[j] = '0;
        eval(4'hF); cyc();
        eval(4'h5); cyc();
        in_valid = 1'b0;
        cyc();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
